// File: rtl/sequence_game_fd.sv
// Parametrised datapath for button-sequence memory games: LFSR pattern source, sequence RAM,
// play capture/compare, show and timeout timers, and a saturating score counter.
module sequence_game_fd #(
    parameter int unsigned N_BUTTONS      = 7,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned SHOW_CYCLES    = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned POINTS_W       = 3,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_BUTTONS-1:0] buttons_i,
    input  logic [1:0]           mode_i,
    input  logic [ADDR_W:0]      seq_len_i,
    input  logic [1:0]           out_sel_i,
    input  logic                 clear_addr_i,
    input  logic                 enable_addr_i,
    input  logic                 gen_write_i,
    input  logic                 clear_ram_i,
    input  logic                 reseed_i,
    input  logic                 clear_reg_i,
    input  logic                 enable_reg_i,
    input  logic                 clear_show_i,
    input  logic                 enable_show_i,
    input  logic                 enable_timeout_i,
    input  logic                 clear_points_i,
    input  logic                 enable_points_i,
    output logic                 end_addr_o,
    output logic                 has_play_o,
    output logic                 correct_play_o,
    output logic                 end_show_o,
    output logic                 half_show_o,
    output logic                 timeout_o,
    output logic [POINTS_W-1:0]  points_o,
    output logic                 points_max_o,
    output logic [N_BUTTONS-1:0] play_o
);

    localparam int unsigned SHOW_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam int unsigned TOUT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [ADDR_W:0]      len_eff, last_addr;
    logic [15:0]          lfsr_q;
    logic [N_BUTTONS-1:0] gen_pat;
    logic [N_BUTTONS-1:0] ram_q [DEPTH];
    logic [N_BUTTONS-1:0] ram_rd;
    logic [N_BUTTONS-1:0] play_q;
    logic                 prev_q, has_play_q;
    logic [SHOW_W-1:0]    show_q;
    logic [TOUT_W-1:0]    tout_q;
    logic [POINTS_W-1:0]  points_q;
    int unsigned          idx_i, idx_j;

    always_comb begin
        if (seq_len_i == '0) begin
            len_eff = (ADDR_W+1)'(1);
        end else if (seq_len_i > (ADDR_W+1)'(DEPTH)) begin
            len_eff = (ADDR_W+1)'(DEPTH);
        end else begin
            len_eff = seq_len_i;
        end
        last_addr  = len_eff - (ADDR_W+1)'(1);
        end_addr_o = ({1'b0, addr_q} == last_addr);
        // An address beyond the current length keeps counting up until it wraps at DEPTH.
        addr_d = end_addr_o ? '0 : addr_q + ADDR_W'(1);
    end

    always_comb begin
        idx_i   = 32'(lfsr_q[7:0]) % N_BUTTONS;
        idx_j   = (idx_i + 1 + (32'(lfsr_q[15:8]) % (N_BUTTONS - 1))) % N_BUTTONS;
        gen_pat = '0;
        case (mode_i)
            2'd0: begin
                gen_pat = lfsr_q[N_BUTTONS-1:0];
                if (gen_pat == '0) gen_pat = N_BUTTONS'(1);
            end
            2'd2:    gen_pat = (N_BUTTONS'(1) << idx_i) | (N_BUTTONS'(1) << idx_j);
            default: gen_pat = N_BUTTONS'(1) << idx_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            lfsr_q <= SEED;
        end else begin
            if (clear_addr_i)       addr_q <= '0;
            else if (enable_addr_i) addr_q <= addr_d;
            if (reseed_i)  lfsr_q <= SEED;
            else if (lfsr_q[0]) lfsr_q <= (lfsr_q >> 1) ^ 16'hB400;
            else                lfsr_q <= lfsr_q >> 1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) ram_q[i] <= '0;
        end else if (clear_ram_i) begin
            for (int i = 0; i < int'(DEPTH); i++) ram_q[i] <= '0;
        end else if (gen_write_i) begin
            ram_q[addr_q] <= gen_pat;
        end
    end

    assign ram_rd = ram_q[addr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            play_q     <= '0;
            prev_q     <= 1'b0;
            has_play_q <= 1'b0;
        end else begin
            has_play_q <= (|buttons_i) & ~prev_q;
            if (clear_reg_i) begin
                play_q <= '0;
                prev_q <= 1'b0;
            end else begin
                prev_q <= |buttons_i;
                if (enable_reg_i) play_q <= buttons_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            show_q   <= '0;
            tout_q   <= '0;
            points_q <= '0;
        end else begin
            if (clear_show_i)       show_q <= '0;
            else if (enable_show_i) show_q <= end_show_o ? '0 : show_q + SHOW_W'(1);
            if (!enable_timeout_i)  tout_q <= '0;
            else if (!timeout_o)    tout_q <= tout_q + TOUT_W'(1);
            if (clear_points_i)                       points_q <= '0;
            else if (enable_points_i && !points_max_o) points_q <= points_q + POINTS_W'(1);
        end
    end

    assign end_show_o     = (show_q == SHOW_W'(SHOW_CYCLES - 1));
    assign half_show_o    = (show_q >= SHOW_W'(SHOW_CYCLES / 2));
    assign timeout_o      = (tout_q == TOUT_W'(TIMEOUT_CYCLES - 1));
    assign points_o       = points_q;
    assign points_max_o   = (points_q == '1);
    assign has_play_o     = has_play_q;
    assign correct_play_o = (ram_rd == play_q);

    always_comb begin
        case (out_sel_i)
            2'd0:    play_o = '0;
            2'd1:    play_o = ram_rd;
            2'd2:    play_o = buttons_i;
            default: play_o = play_q;
        endcase
    end

endmodule

// File: tb/tb_sequence_game_fd.sv
// Directed bench for sequence_game_fd: 7-button instance plus a 2-button instance fixed in mode 2.
module tb_sequence_game_fd;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [6:0] buttons = '0;
    logic [1:0] b2 = '0;
    logic [1:0] mode = '0, out_sel = '0;
    logic [4:0] seq_len = '0;
    logic clear_addr = 0, enable_addr = 0, gen_write = 0, clear_ram = 0, reseed = 0;
    logic clear_reg = 0, enable_reg = 0, clear_show = 0, enable_show = 0;
    logic enable_timeout = 0, clear_points = 0, enable_points = 0;

    logic       end_addr, has_play, correct_play, end_show, half_show, timeout, points_max;
    logic [2:0] points;
    logic [6:0] play;
    logic       end_addr2, has_play2, correct_play2, end_show2, half_show2, timeout2, points_max2;
    logic [2:0] points2;
    logic [1:0] play2;

    int unsigned n_checks = 0, n_fail = 0;
    logic [6:0]  exp_mem [5];
    logic [15:0] r;

    always #5 clk_i = ~clk_i;

    sequence_game_fd #(.N_BUTTONS(7), .SHOW_CYCLES(10), .TIMEOUT_CYCLES(20)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .buttons_i(buttons), .mode_i(mode), .seq_len_i(seq_len),
        .out_sel_i(out_sel), .clear_addr_i(clear_addr), .enable_addr_i(enable_addr),
        .gen_write_i(gen_write), .clear_ram_i(clear_ram), .reseed_i(reseed),
        .clear_reg_i(clear_reg), .enable_reg_i(enable_reg), .clear_show_i(clear_show),
        .enable_show_i(enable_show), .enable_timeout_i(enable_timeout),
        .clear_points_i(clear_points), .enable_points_i(enable_points),
        .end_addr_o(end_addr), .has_play_o(has_play), .correct_play_o(correct_play),
        .end_show_o(end_show), .half_show_o(half_show), .timeout_o(timeout),
        .points_o(points), .points_max_o(points_max), .play_o(play)
    );

    sequence_game_fd #(.N_BUTTONS(2), .SHOW_CYCLES(10), .TIMEOUT_CYCLES(20)) dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .buttons_i(b2), .mode_i(2'd2), .seq_len_i(seq_len),
        .out_sel_i(out_sel), .clear_addr_i(clear_addr), .enable_addr_i(enable_addr),
        .gen_write_i(gen_write), .clear_ram_i(clear_ram), .reseed_i(reseed),
        .clear_reg_i(clear_reg), .enable_reg_i(enable_reg), .clear_show_i(clear_show),
        .enable_show_i(enable_show), .enable_timeout_i(enable_timeout),
        .clear_points_i(clear_points), .enable_points_i(enable_points),
        .end_addr_o(end_addr2), .has_play_o(has_play2), .correct_play_o(correct_play2),
        .end_show_o(end_show2), .half_show_o(half_show2), .timeout_o(timeout2),
        .points_o(points2), .points_max_o(points_max2), .play_o(play2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [6:0] pat(input logic [1:0] m, input logic [15:0] s);
        int unsigned i, j;
        logic [6:0] p;
        i = 32'(s[7:0]) % 7;
        j = (i + 1 + 32'(s[15:8]) % 6) % 7;
        case (m)
            2'd0:    p = (s[6:0] == 7'd0) ? 7'd1 : s[6:0];
            2'd2:    p = (7'd1 << i) | (7'd1 << j);
            default: p = 7'd1 << i;
        endcase
        return p;
    endfunction

    // Reseed, then write five generated patterns at addresses 0..4 while the address advances.
    task automatic fill(input logic [1:0] m);
        mode = m; seq_len = 5'd5; clear_addr = 1; reseed = 1;
        tick();
        clear_addr = 0; reseed = 0; gen_write = 1; enable_addr = 1;
        r = 16'hACE1;
        for (int k = 0; k < 5; k++) begin
            check("fill_end_addr", 32'(end_addr), 32'(k == 4));
            exp_mem[k] = pat(m, r);
            r = lfsr_step(r);
            tick();
        end
        gen_write = 0; enable_addr = 0;
        check("fill_wrapped", 32'(end_addr), 32'd0);
    endtask

    task automatic readback();
        out_sel = 2'd1; seq_len = 5'd20;
        #1;
        for (int a = 0; a < 16; a++) begin
            check("rd_data", 32'(play), (a < 5) ? 32'(exp_mem[a]) : 32'd0);
            check("rd_n2", 32'(play2), (a < 5) ? 32'd3 : 32'd0);
            if (a < 5) check("rd_onehot", $countones(play), 32'd1);
            check("rd_end_addr", 32'(end_addr), 32'(a == 15));
            enable_addr = 1;
            tick();
        end
        enable_addr = 0;
    endtask

    initial begin
        int unsigned n, zeros, bad, bad2;
        logic [6:0] e;
        #2;
        check("rst_end_addr_l1", 32'(end_addr), 32'd1);
        check("rst_has_play", 32'(has_play), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_points", 32'(points), 32'd0);
        check("rst_points_max", 32'(points_max), 32'd0);
        out_sel = 2'd3; #1;
        check("rst_play", 32'(play), 32'd0);
        #10 rst_ni = 1;
        tick();

        fill(2'd1);
        out_sel = 2'd1; #1;
        check("ram0_hand", 32'(play), 32'h02);
        enable_addr = 1; tick(); enable_addr = 0;
        check("ram1_hand", 32'(play), 32'h01);
        clear_addr = 1; tick(); clear_addr = 0;
        readback();

        // Mode 3 after a reseed must reproduce the mode 1 sequence.
        clear_ram = 1; gen_write = 1; tick(); clear_ram = 0; gen_write = 0;
        out_sel = 2'd1; #1;
        check("clear_ram", 32'(play), 32'd0);
        fill(2'd3);
        readback();

        mode = 2'd1; clear_addr = 1; reseed = 1; tick(); clear_addr = 0; reseed = 0;
        r = 16'hACE1; n = 0;
        while (pat(2'd1, r) != 7'b0000100 && n < 200) begin
            r = lfsr_step(r); n++; tick();
        end
        check("find_pattern", 32'(n < 200), 32'd1);
        gen_write = 1; tick(); gen_write = 0;
        out_sel = 2'd1; #1;
        check("ram0_target", 32'(play), 32'h04);
        buttons = 7'b0000100; enable_reg = 1; tick(); enable_reg = 0;
        check("has_play_pulse", 32'(has_play), 32'd1);
        check("correct_play_hit", 32'(correct_play), 32'd1);
        tick();
        check("has_play_held", 32'(has_play), 32'd0);
        buttons = 7'b0001000; enable_reg = 1; tick(); enable_reg = 0;
        check("correct_play_miss", 32'(correct_play), 32'd0);
        check("has_play_no_edge", 32'(has_play), 32'd0);
        out_sel = 2'd3; #1;
        check("play_reg_out", 32'(play), 32'h08);
        out_sel = 2'd2; buttons = 7'b0000011; #1;
        check("play_buttons", 32'(play), 32'h03);
        out_sel = 2'd0; #1;
        check("play_zero", 32'(play), 32'd0);
        buttons = '0; tick(); buttons = 7'b0000100; tick();
        check("has_play_retrigger", 32'(has_play), 32'd1);
        tick();
        check("has_play_one_cycle", 32'(has_play), 32'd0);

        clear_show = 1; enable_show = 1; tick(); clear_show = 0;
        for (int c = 0; c < 12; c++) begin
            check("half_show", 32'(half_show), 32'((c % 10) >= 5));
            check("end_show", 32'(end_show), 32'((c % 10) == 9));
            tick();
        end
        enable_show = 0;

        enable_timeout = 1;
        for (int c = 0; c < 25; c++) begin
            check("timeout", 32'(timeout), 32'(c >= 19));
            tick();
        end
        enable_timeout = 0; tick();
        check("timeout_drop", 32'(timeout), 32'd0);

        clear_points = 1; tick(); clear_points = 0; enable_points = 1;
        for (int c = 0; c < 9; c++) begin
            check("points_count", 32'(points), (c > 7) ? 32'd7 : 32'(c));
            tick();
        end
        check("points_sat", 32'(points), 32'd7);
        check("points_max", 32'(points_max), 32'd1);
        clear_points = 1; tick(); clear_points = 0; enable_points = 0;
        check("points_clear_wins", 32'(points), 32'd0);
        check("points_max_clr", 32'(points_max), 32'd0);

        mode = 2'd0; clear_addr = 1; reseed = 1; tick(); clear_addr = 0; reseed = 0;
        r = 16'hACE1; gen_write = 1; out_sel = 2'd1;
        zeros = 0; bad = 0; bad2 = 0;
        for (int k = 0; k < 1000; k++) begin
            e = pat(2'd0, r);
            r = lfsr_step(r);
            tick();
            if (play == 7'd0) zeros++;
            if (play != e) bad++;
            if (play2 != 2'b11) bad2++;
        end
        gen_write = 0;
        check("mode0_nonzero", zeros, 32'd0);
        check("mode0_model", bad, 32'd0);
        check("mode2_n2_all_11", bad2, 32'd0);

        enable_points = 1; enable_timeout = 1;
        for (int c = 0; c < 22; c++) tick();
        check("pre_rst_timeout", 32'(timeout), 32'd1);
        #2 rst_ni = 0; #1;
        check("async_rst_points", 32'(points), 32'd0);
        check("async_rst_timeout", 32'(timeout), 32'd0);
        check("async_rst_ram", 32'(play), 32'd0);
        enable_points = 0; enable_timeout = 0;
        #10 rst_ni = 1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
